// File: rtl/prefetch_queue.sv
// prefetch_queue: line-aligning, de-duplicating FIFO between the stride
// prefetcher and the L2/physical-memory read port.
//
// Each cycle a candidate prefetch (pf_addr/pf_valid) is aligned to a cache
// line. It is queued unless one of these holds:
//   - the line is already queued;
//   - the line is currently in flight;
//   - the queue is full and nothing leaves it this cycle;
//   - flush is asserted.
// Queued lines are issued one at a time through a three-state FSM
// (IDLE -> REQ -> DONE). A new issue is never started while demand_busy is
// high. An issue that is already in flight always runs to completion.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   pf_addr        candidate prefetch address
//   pf_valid       pf_addr is valid this cycle
//   demand_busy    L2 is servicing a demand miss; blocks new issue
//   flush          synchronous clear of all queued (not in-flight) entries
//   pmem_addr      line-aligned read address; holds its last value outside REQ
//   pmem_read      read request, held until pmem_resp
//   pmem_resp      one-cycle completion of the outstanding read
//   pf_done        one-cycle pulse in the cycle after pmem_resp
//   count          number of queued entries (excludes the in-flight one)
//   full, empty    count==DEPTH, count==0
//   drop_cnt       (PFQ_DROP_CNT_EN only) saturating count of rejected candidates
//
// Optional feature: define PFQ_DROP_CNT_EN to add the drop_cnt output.
module prefetch_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int LINE_OFF = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      pf_addr,
    input  logic                   pf_valid,
    input  logic                   demand_busy,
    input  logic                   flush,
    output logic [ADDR_W-1:0]      pmem_addr,
    output logic                   pmem_read,
    input  logic                   pmem_resp,
    output logic                   pf_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
`ifdef PFQ_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ent_line [DEPTH];
    logic [DEPTH-1:0]  ent_vld;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic [ADDR_W-1:0] line;
    logic              hit_q;
    logic              hit_fly;
    logic              deq;
    logic              enq;

    // Masking keeps every pf_addr bit in use; the low offset bits become zero.
    assign line = pf_addr & ALIGN_MASK;

    always_comb begin
        hit_q = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_line[i] == line)) begin
                hit_q = 1'b1;
            end
        end
    end

    // pmem_addr holds the in-flight line for the whole of REQ and DONE.
    assign hit_fly = (state != IDLE) && (pmem_addr == line);

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign deq = (state == IDLE) && !empty && !demand_busy && !flush;

    // When full, the head slot is freed this same edge, so the write at tail
    // (which then equals head) is safe.
    assign enq = pf_valid && !flush && !hit_q && !hit_fly && (!full || deq);

    // Queue control: pointers, valid bits and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            // The clear comes before the set, so a full-queue enqueue into the
            // slot just vacated leaves that slot valid.
            if (deq) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (enq) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            if (enq && !deq) begin
                count <= count + CNT_W'(1);
            end else if (deq && !enq) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry payload; validity is tracked by ent_vld, so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_line[tail] <= line;
        end
    end

    // Issue FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pmem_addr <= '0;
            pmem_read <= 1'b0;
            pf_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pf_done <= 1'b0;
                    if (deq) begin
                        pmem_addr <= ent_line[head];
                        pmem_read <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // An in-flight read cannot be aborted; demand_busy and
                    // flush have no effect here.
                    if (pmem_resp) begin
                        pmem_read <= 1'b0;
                        pf_done   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    pf_done <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    pmem_read <= 1'b0;
                    pf_done   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef PFQ_DROP_CNT_EN
    // Counts every valid candidate that is not queued, for whatever reason.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (pf_valid && !enq && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue. A reference model holds the queue
// as a list of lines plus an in-flight phase. It is advanced at every rising
// edge, and the DUT outputs are compared 1 ns after the edge.
module tb_prefetch_queue;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 32;
    localparam int LINE_OFF = 5;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
`ifdef PFQ_DROP_CNT_EN
    localparam int VW = 4 + CNT_W + ADDR_W + 16;
`else
    localparam int VW = 4 + CNT_W + ADDR_W;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] pf_addr = '0;
    logic              pf_valid = 1'b0;
    logic              demand_busy = 1'b0;
    logic              flush = 1'b0;
    logic              pmem_resp = 1'b0;
    logic [ADDR_W-1:0] pmem_addr;
    logic              pmem_read;
    logic              pf_done;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
`ifdef PFQ_DROP_CNT_EN
    logic [15:0]       drop_cnt;
    logic [15:0]       d0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [ADDR_W-1:0] m_q[$];
    int                m_phase = 0;   // 0 idle, 1 request out, 2 done pulse
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [15:0]       m_drop  = '0;

    prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_OFF(LINE_OFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pf_addr    (pf_addr),
        .pf_valid   (pf_valid),
        .demand_busy(demand_busy),
        .flush      (flush),
        .pmem_addr  (pmem_addr),
        .pmem_read  (pmem_read),
        .pmem_resp  (pmem_resp),
        .pf_done    (pf_done),
        .count      (count),
        .full       (full),
        .empty      (empty)
`ifdef PFQ_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_q.delete();
        m_phase = 0;
        m_addr  = '0;
        m_drop  = '0;
    endtask

    // Applies the queue rules to the inputs sampled at this edge.
    task automatic model_edge();
        logic [ADDR_W-1:0] ln;
        bit dup, dq, eq;
        if (!rst_n) begin
            m_reset();
            return;
        end
        ln  = (pf_addr >> LINE_OFF) << LINE_OFF;
        dup = 0;
        foreach (m_q[i]) if (m_q[i] == ln) dup = 1;
        if (m_phase != 0 && m_addr == ln) dup = 1;
        dq = (m_phase == 0) && (m_q.size() != 0) && !demand_busy && !flush;
        eq = pf_valid && !flush && !dup && ((m_q.size() < DEPTH) || dq);
        if (pf_valid && !eq && m_drop != 16'hFFFF) m_drop++;
        case (m_phase)
            0: if (dq) m_phase = 1;
            1: if (pmem_resp) m_phase = 2;
            default: m_phase = 0;
        endcase
        if (flush) begin
            m_q.delete();
        end else begin
            if (dq) m_addr = m_q.pop_front();
            if (eq) m_q.push_back(ln);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a,
                         input logic busy, input logic fl, input logic resp);
        pf_valid    = v;
        pf_addr     = a;
        demand_busy = busy;
        flush       = fl;
        pmem_resp   = resp;
    endtask

    function automatic logic [VW-1:0] exp_vec();
`ifdef PFQ_DROP_CNT_EN
        return {m_phase == 1, m_phase == 2, m_q.size() == DEPTH, m_q.size() == 0,
                CNT_W'(m_q.size()), m_addr, m_drop};
`else
        return {m_phase == 1, m_phase == 2, m_q.size() == DEPTH, m_q.size() == 0,
                CNT_W'(m_q.size()), m_addr};
`endif
    endfunction

    function automatic logic [VW-1:0] obs_vec();
`ifdef PFQ_DROP_CNT_EN
        return {pmem_read, pf_done, full, empty, count, pmem_addr, drop_cnt};
`else
        return {pmem_read, pf_done, full, empty, count, pmem_addr};
`endif
    endfunction

    task automatic test_reset();
        drive(0, '0, 0, 0, 0);
        step();
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
        end
        rst_n = 1'b1;
        step();
        // Put a read in flight, then reset asynchronously between edges.
        drive(1, 32'h500, 0, 0, 0);
        step();
        drive(0, '0, 0, 0, 0);
        step();
        n_cmp++;
        if (pmem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_setup_req: got read=%b want 1", pmem_read);
        end
        rst_n = 1'b0;
        #1;
        m_reset();
        n_cmp++;
        if (pmem_read !== 1'b0 || empty !== 1'b1 || count !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got read=%b empty=%b count=%0d want 0 1 0",
                     pmem_read, empty, count);
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_basic_issue();
        drive(1, 32'h0000_1234, 0, 0, 0);
        step();
        drive(0, '0, 0, 0, 0);
        n_cmp++;
        if (count !== CNT_W'(1) || pmem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_enqueue: got count=%0d read=%b want 1 0", count, pmem_read);
        end
        step();
        n_cmp++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_1220) begin
            n_fail++;
            $display("FAIL basic_issue: got read=%b addr=%h want 1 00001220", pmem_read, pmem_addr);
        end
        step();
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL basic_hold: got %h want %h", obs_vec(), exp_vec());
        end
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        n_cmp++;
        if (pf_done !== 1'b1 || pmem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b read=%b want 1 0", pf_done, pmem_read);
        end
        step();
        n_cmp++;
        if (pf_done !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL basic_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_dedup();
        logic [ADDR_W-1:0] seq [5] = '{32'h100, 32'h104, 32'h11C, 32'h100, 32'h120};
`ifdef PFQ_DROP_CNT_EN
        d0 = drop_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            drive(1, seq[i], 1, 0, 0);
            step();
        end
        drive(0, '0, 1, 0, 0);
        n_cmp++;
        if (count !== CNT_W'(2) || pmem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL dedup_count: got count=%0d read=%b want 2 0", count, pmem_read);
        end
`ifdef PFQ_DROP_CNT_EN
        n_cmp++;
        if (drop_cnt - d0 !== 16'd3) begin
            n_fail++;
            $display("FAIL dedup_drops: got %0d want 3", drop_cnt - d0);
        end
`endif
        demand_busy = 1'b0;
        step();
        n_cmp++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL dedup_first: got read=%b addr=%h want 1 00000100", pmem_read, pmem_addr);
        end
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        step();
        step();
        n_cmp++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h120) begin
            n_fail++;
            $display("FAIL dedup_second: got read=%b addr=%h want 1 00000120", pmem_read, pmem_addr);
        end
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL dedup_end: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            drive(1, ADDR_W'(i * 32'h20), 1, 0, 0);
            step();
        end
        n_cmp++;
        if (full !== 1'b1 || count !== CNT_W'(4) || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_drop: got full=%b count=%0d want 1 4", full, count);
        end
        drive(1, 32'h0A0, 0, 0, 0);
        step();
        n_cmp++;
        if (count !== CNT_W'(4) || full !== 1'b1 || pmem_read !== 1'b1 || pmem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL full_swap: got count=%0d full=%b read=%b addr=%h want 4 1 1 00000000",
                     count, full, pmem_read, pmem_addr);
        end
        drive(0, '0, 0, 1, 0);
        step();
        drive(0, '0, 0, 0, 1);
        step();
        pmem_resp = 1'b0;
        step();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_end: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_flush();
        drive(1, 32'h200, 0, 0, 0);
        step();
        drive(0, '0, 0, 0, 0);
        step();
        drive(1, 32'h240, 0, 0, 0);
        step();
        drive(1, 32'h280, 0, 0, 0);
        step();
        n_cmp++;
        if (count !== CNT_W'(2) || pmem_addr !== 32'h200 || pmem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: got count=%0d addr=%h read=%b want 2 00000200 1",
                     count, pmem_addr, pmem_read);
        end
        drive(1, 32'h300, 0, 1, 0);
        step();
        drive(0, '0, 0, 0, 0);
        n_cmp++;
        if (count !== '0 || empty !== 1'b1 || pmem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: got count=%0d empty=%b read=%b want 0 1 1",
                     count, empty, pmem_read);
        end
        step();
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        n_cmp++;
        if (pf_done !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL flush_complete: got done=%b want 1", pf_done);
        end
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (pmem_read !== 1'b0 || pf_done !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL flush_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_busy_during_req();
        drive(1, 32'h400, 0, 0, 0);
        step();
        drive(1, 32'h440, 0, 0, 0);
        step();
        drive(0, '0, 1, 0, 0);
        step();
        step();
        n_cmp++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h400 || count !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL busy_hold: got read=%b addr=%h count=%0d want 1 00000400 1",
                     pmem_read, pmem_addr, count);
        end
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (pmem_read !== 1'b0 || count !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL busy_block: got read=%b count=%0d want 0 1", pmem_read, count);
        end
        demand_busy = 1'b0;
        step();
        n_cmp++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h440) begin
            n_fail++;
            $display("FAIL busy_release: got read=%b addr=%h want 1 00000440", pmem_read, pmem_addr);
        end
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom % 2), ADDR_W'($urandom_range(0, 511)),
                  1'(($urandom % 10) < 3), 1'(($urandom % 20) == 0),
                  1'(($urandom % 3) == 0));
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        drive(0, '0, 0, 0, 0);
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic_issue();
        test_dedup();
        test_full();
        test_flush();
        test_busy_during_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
